// File: rtl/bundle_fetch_if.sv
// Fetch-side bus bundle: instruction-memory read port plus the bundle
// valid/ready handshake towards decode/issue.
interface bundle_fetch_if #(
  parameter int unsigned SLOTS = 10,
  parameter int unsigned IW    = 32
);
  logic                imem_rd_en;
  logic [31:0]         imem_addr;
  logic [SLOTS*IW-1:0] imem_rdata;
  logic                bundle_valid;
  logic                bundle_ready;
  logic [SLOTS*IW-1:0] bundle_data;
  logic [31:0]         bundle_pc;
  logic [SLOTS-1:0]    slot_valid;

  modport master (
    output imem_rd_en, imem_addr,
    input  imem_rdata,
    output bundle_valid, bundle_data, bundle_pc, slot_valid,
    input  bundle_ready
  );

  modport slave (
    input  imem_rd_en, imem_addr,
    output imem_rdata,
    input  bundle_valid, bundle_data, bundle_pc, slot_valid,
    output bundle_ready
  );
endinterface

// File: rtl/bundle_fetch.sv
// VLIW instruction-bundle fetch: walks the bundle PC, reads imem with one-cycle
// latency into a 2-entry buffer and presents bundles over valid/ready.
module bundle_fetch #(
  parameter int unsigned SLOTS    = 10,
  parameter int unsigned IW       = 32,
  parameter logic [31:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  bundle_fetch_if.master        bus,
  input  logic                  redirect_valid,
  input  logic [31:0]           redirect_pc,
  input  logic                  halt,
  output logic [31:0]           fetch_count
);
  localparam int unsigned BW = SLOTS * IW;

  logic [31:0]   pc_q, pc_d;
  logic [BW-1:0] buf_data_q [2];
  logic [BW-1:0] buf_data_d [2];
  logic [31:0]   buf_pc_q [2];
  logic [31:0]   buf_pc_d [2];
  logic          rd_ptr_q, rd_ptr_d;
  logic [1:0]    count_q, count_d;
  logic          inflight_q, inflight_d;
  logic [31:0]   inflight_pc_q, inflight_pc_d;
  logic [31:0]   fetch_count_q, fetch_count_d;

  logic          head_valid;
  logic [BW-1:0] head_data;
  logic [31:0]   head_pc;
  logic [SLOTS-1:0] slots;
  logic          pop, push, issue, wr_ptr;
  logic [1:0]    occupancy;

  always_comb begin
    head_valid = (count_q != 2'd0);
    head_data  = head_valid ? buf_data_q[rd_ptr_q] : '0;
    head_pc    = head_valid ? buf_pc_q[rd_ptr_q] : '0;
    slots      = '0;
    for (int unsigned k = 0; k < SLOTS; k++)
      slots[k] = |head_data[BW-1-IW*k -: IW];
  end

  // A return landing in the redirect cycle is gated here; since no read issues
  // in that cycle, nothing stale can still be in flight afterwards.
  always_comb begin
    pop       = head_valid && bus.bundle_ready;
    push      = inflight_q && !redirect_valid;
    occupancy = count_q + {1'b0, inflight_q} - {1'b0, pop};
    issue     = !rst && !halt && !redirect_valid && (occupancy < 2'd2);
    wr_ptr    = rd_ptr_q ^ count_q[0];

    pc_d          = pc_q;
    buf_data_d    = buf_data_q;
    buf_pc_d      = buf_pc_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    inflight_d    = issue;
    inflight_pc_d = issue ? pc_q : inflight_pc_q;
    fetch_count_d = fetch_count_q + {31'b0, pop};

    if (redirect_valid) begin
      pc_d     = redirect_pc;
      count_d  = '0;
      rd_ptr_d = 1'b0;
    end else begin
      if (issue) pc_d = pc_q + 32'd1;
      if (push) begin
        buf_data_d[wr_ptr] = bus.imem_rdata;
        buf_pc_d[wr_ptr]   = inflight_pc_q;
      end
      if (pop) rd_ptr_d = ~rd_ptr_q;
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      buf_data_q    <= '{default: '0};
      buf_pc_q      <= '{default: '0};
      rd_ptr_q      <= 1'b0;
      count_q       <= '0;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      fetch_count_q <= '0;
    end else begin
      pc_q          <= pc_d;
      buf_data_q    <= buf_data_d;
      buf_pc_q      <= buf_pc_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign bus.imem_rd_en   = issue;
  assign bus.imem_addr    = pc_q;
  assign bus.bundle_valid = head_valid;
  assign bus.bundle_data  = head_data;
  assign bus.bundle_pc    = head_pc;
  assign bus.slot_valid   = slots;
  assign fetch_count      = fetch_count_q;

  buffer_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && count_q == 2'd2));
endmodule
